// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store initiator: access sizes, FSM states and memory size default.
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int unsigned LSU_MEM_BYTES = 4096;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RD   = 2'b01,
      WR   = 2'b10,
      RESP = 2'b11
   } state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: sub-word load extract with sign/zero extension,
// and the store merge that replaces only the target lanes of a fetched word.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [31:0] word_i,
   input  logic [31:0] wdata_i,
   input  logic [1:0]  size_i,
   input  logic [1:0]  offset_i,
   input  logic        signed_i,
   output logic [31:0] load_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      byte_v   = word_i[{offset_i, 3'b000} +: 8];
      half_v   = offset_i[1] ? word_i[31:16] : word_i[15:0];
      load_o   = word_i;
      merged_o = wdata_i;
      case (size_i)
         SZ_BYTE: begin
            load_o   = {{24{signed_i & byte_v[7]}}, byte_v};
            merged_o = word_i;
            merged_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_HALF: begin
            load_o   = {{16{signed_i & half_v[15]}}, half_v};
            merged_o = word_i;
            merged_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator to a word-addressed memory with RMW for sub-word stores.
// Define LSU_STATS_EN to build the saturating load/store/fault counters.
module lsu_mem_initiator
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_BYTES = LSU_MEM_BYTES,
   parameter int unsigned ADDR_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_misaligned,
   output logic              resp_range_err,
   output logic [31:0]       mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [31:0]       mem_rdata,
   output logic [31:0]       stat_loads,
   output logic [31:0]       stat_stores,
   output logic [31:0]       stat_faults
);

   state_e            state_q, state_d;
   logic              write_q, signed_q, mis_q, rng_q;
   logic [1:0]        size_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, merged_q, resp_rdata_q;
   logic              accept, req_mis, req_rng;
   logic [31:0]       ld_data, merge_data;

   assign accept  = req_valid && (state_q == IDLE);
   assign req_rng = req_addr >= ADDR_W'(MEM_BYTES);

   always_comb begin
      case (req_size)
         SZ_BYTE: req_mis = 1'b0;
         SZ_HALF: req_mis = req_addr[0];
         SZ_WORD: req_mis = |req_addr[1:0];
         default: req_mis = 1'b1;
      endcase
   end

   lsu_lane_align u_align (
      .word_i   (mem_rdata),
      .wdata_i  (wdata_q),
      .size_i   (size_q),
      .offset_i (addr_q[1:0]),
      .signed_i (signed_q),
      .load_o   (ld_data),
      .merged_o (merge_data)
   );

   always_comb begin
      state_d         = state_q;
      req_ready       = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_addr        = '0;
      mem_wdata       = '0;
      resp_valid      = 1'b0;
      resp_misaligned = 1'b0;
      resp_range_err  = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               if (req_mis || req_rng)                     state_d = RESP;
               else if (req_write && req_size == SZ_WORD)  state_d = WR;
               else                                        state_d = RD;
            end
         end
         RD: begin
            mem_read = 1'b1;
            mem_addr = 32'({addr_q[ADDR_W-1:2], 2'b00});
            state_d  = write_q ? WR : RESP;
         end
         WR: begin
            mem_write = 1'b1;
            mem_addr  = 32'({addr_q[ADDR_W-1:2], 2'b00});
            mem_wdata = (size_q == SZ_WORD) ? wdata_q : merged_q;
            state_d   = RESP;
         end
         RESP: begin
            resp_valid      = 1'b1;
            resp_misaligned = mis_q;
            resp_range_err  = rng_q;
            state_d         = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign resp_rdata = resp_rdata_q;

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         signed_q     <= 1'b0;
         mis_q        <= 1'b0;
         rng_q        <= 1'b0;
         size_q       <= SZ_BYTE;
         addr_q       <= '0;
         wdata_q      <= '0;
         merged_q     <= '0;
         resp_rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            write_q  <= req_write;
            signed_q <= req_signed;
            mis_q    <= req_mis;
            rng_q    <= req_rng;
            size_q   <= req_size;
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            if (req_mis || req_rng) resp_rdata_q <= '0;
         end
         // mem_rdata is only meaningful (non-Z) while RD drives mem_read.
         if (state_q == RD) begin
            merged_q <= merge_data;
            if (!write_q) resp_rdata_q <= ld_data;
         end
         if (state_q == WR) resp_rdata_q <= '0;
      end
   end

`ifdef LSU_STATS_EN
   logic [31:0] loads_q, stores_q, faults_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loads_q  <= '0;
         stores_q <= '0;
         faults_q <= '0;
      end else if (state_q == RESP) begin
         if (mis_q || rng_q) begin
            if (faults_q != '1) faults_q <= faults_q + 32'd1;
         end else if (write_q) begin
            if (stores_q != '1) stores_q <= stores_q + 32'd1;
         end else begin
            if (loads_q != '1) loads_q <= loads_q + 32'd1;
         end
      end
   end

   assign stat_loads  = loads_q;
   assign stat_stores = stores_q;
   assign stat_faults = faults_q;
`else
   assign stat_loads  = '0;
   assign stat_stores = '0;
   assign stat_faults = '0;
`endif

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator: stimulus pushes expected responses, a monitor pops on resp_valid.
module tb_lsu_mem_initiator;
   import lsu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_signed;
   logic [1:0]  req_size;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_misaligned, resp_range_err;
   logic [31:0] resp_rdata, mem_addr, mem_wdata;
   logic        mem_read, mem_write;
   wire  [31:0] mem_rdata;
   logic [31:0] stat_loads, stat_stores, stat_faults;

   logic [31:0] mem [0:1023];

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      logic        rng;
      int          lat;
      int          acc;
      string       nm;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   int          cyc = 0;
   int          wr_cnt = 0;
   int          rd_cnt = 0;
   logic        both_seen = 1'b0;
   logic [31:0] last_waddr = '0;

   lsu_mem_initiator dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_write       (req_write),
      .req_size        (req_size),
      .req_signed      (req_signed),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_misaligned (resp_misaligned),
      .resp_range_err  (resp_range_err),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_rdata       (mem_rdata),
      .stat_loads      (stat_loads),
      .stat_stores     (stat_stores),
      .stat_faults     (stat_faults)
   );

   always #5 clk = ~clk;

   // Memory model: combinational read, posedge write, Z when not reading.
   assign mem_rdata = mem_read ? mem[mem_addr[11:2]] : 32'bz;
   always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_wdata;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mem_write) begin
         wr_cnt++;
         last_waddr = mem_addr;
      end
      if (mem_read) rd_cnt++;
      if (mem_read && mem_write) both_seen = 1'b1;
      if (rst_n && resp_valid) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL spurious_resp: resp_valid with nothing outstanding, rdata 0x%08h", resp_rdata);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.nm, "_rdata"}, resp_rdata, e.rdata);
            check({e.nm, "_mis"}, 32'(resp_misaligned), 32'(e.mis));
            check({e.nm, "_rng"}, 32'(resp_range_err), 32'(e.rng));
            check({e.nm, "_lat"}, 32'(cyc - e.acc + 1), 32'(e.lat));
         end
      end
   end

   // Presents one request and holds it until accepted; keep=1 leaves req_valid high afterwards.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis, input logic exp_rng,
                        input int exp_lat, input string nm, input bit keep);
      int   n;
      exp_t e;
      req_write  = wr;
      req_size   = sz;
      req_signed = sg;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_accept: req_ready stayed 0 for %0d cycles, required 1", nm, n);
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      e.rdata = exp_rd;
      e.mis   = exp_mis;
      e.rng   = exp_rng;
      e.lat   = exp_lat;
      e.acc   = cyc;
      e.nm    = nm;
      sb.push_back(e);
      if (!keep) req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string nm);
      int n;
      n = 0;
      while ((sb.size() != 0 || !req_ready) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_drain: %0d responses still outstanding, required 0", nm, sb.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
      $fatal(1, "watchdog");
   end

   initial begin
      int w0, r0;
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE;
      req_signed = 1'b0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_resp_valid", 32'(resp_valid), 32'd0);
      check("rst_mem_read", 32'(mem_read), 32'd0);
      check("rst_mem_write", 32'(mem_write), 32'd0);
      check("rst_mem_addr", mem_addr, 32'd0);
      check("rst_mem_wdata", mem_wdata, 32'd0);
      check("rst_resp_rdata", resp_rdata, 32'd0);
      check("rst_flags", 32'({resp_misaligned, resp_range_err}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Word store then word load.
      issue(1'b1, SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0, 2, "st_w10", 1'b0);
      wait_drain("st_w10");
      check("st_w10_wcnt", 32'(wr_cnt), 32'd1);
      check("st_w10_waddr", last_waddr, 32'h10);
      check("st_w10_mem", mem[4], 32'hDEADBEEF);
      issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 2, "ld_w10", 1'b0);

      // Preload words used by the sub-word tests.
      issue(1'b1, SZ_WORD, 1'b0, 32'h20, 32'h11223344, 32'h0, 1'b0, 1'b0, 2, "pre20", 1'b0);
      issue(1'b1, SZ_WORD, 1'b0, 32'h24, 32'h12345678, 32'h0, 1'b0, 1'b0, 2, "pre24", 1'b0);
      issue(1'b1, SZ_WORD, 1'b0, 32'h30, 32'h55667788, 32'h0, 1'b0, 1'b0, 2, "pre30", 1'b0);
      issue(1'b1, SZ_WORD, 1'b0, 32'hFFC, 32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 2, "preffc", 1'b0);
      wait_drain("pre");

      // Byte read-modify-write, then extracts.
      w0 = wr_cnt;
      issue(1'b1, SZ_BYTE, 1'b0, 32'h22, 32'h123456AA, 32'h0, 1'b0, 1'b0, 3, "st_b22", 1'b0);
      wait_drain("st_b22");
      check("st_b22_wcnt", 32'(wr_cnt - w0), 32'd1);
      check("st_b22_mem", mem[8], 32'h11AA3344);
      issue(1'b0, SZ_BYTE, 1'b1, 32'h22, 32'h0, 32'hFFFFFFAA, 1'b0, 1'b0, 2, "ld_sb22", 1'b0);
      issue(1'b0, SZ_BYTE, 1'b0, 32'h22, 32'h0, 32'h000000AA, 1'b0, 1'b0, 2, "ld_ub22", 1'b0);
      issue(1'b0, SZ_BYTE, 1'b0, 32'h23, 32'h0, 32'h00000011, 1'b0, 1'b0, 2, "ld_ub23", 1'b0);
      issue(1'b0, SZ_BYTE, 1'b1, 32'h20, 32'h0, 32'h00000044, 1'b0, 1'b0, 2, "ld_sb20", 1'b0);

      // Halfword read-modify-write, then extracts.
      issue(1'b1, SZ_HALF, 1'b0, 32'h26, 32'hBEEF8001, 32'h0, 1'b0, 1'b0, 3, "st_h26", 1'b0);
      wait_drain("st_h26");
      check("st_h26_mem", mem[9], 32'h80015678);
      issue(1'b0, SZ_HALF, 1'b1, 32'h26, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, 2, "ld_sh26", 1'b0);
      issue(1'b0, SZ_HALF, 1'b0, 32'h24, 32'h0, 32'h00005678, 1'b0, 1'b0, 2, "ld_uh24", 1'b0);
      issue(1'b0, SZ_WORD, 1'b0, 32'hFFC, 32'h0, 32'hA5A5A5A5, 1'b0, 1'b0, 2, "ld_wffc", 1'b0);
      wait_drain("ld");

      // Faults never touch memory.
      w0 = wr_cnt;
      r0 = rd_cnt;
      issue(1'b0, SZ_WORD, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 1'b0, 1, "f_w13", 1'b0);
      issue(1'b0, SZ_WORD, 1'b0, 32'h1000, 32'h0, 32'h0, 1'b0, 1'b1, 1, "f_w1000", 1'b0);
      issue(1'b0, 2'b11, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1, "f_sz11", 1'b0);
      issue(1'b0, SZ_HALF, 1'b0, 32'h1001, 32'h0, 32'h0, 1'b1, 1'b1, 1, "f_h1001", 1'b0);
      issue(1'b1, SZ_WORD, 1'b0, 32'h2, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1, "f_sw2", 1'b0);
      issue(1'b1, SZ_BYTE, 1'b0, 32'h1000, 32'h77, 32'h0, 1'b0, 1'b1, 1, "f_sb1000", 1'b0);
      wait_drain("faults");
      check("faults_rcnt", 32'(rd_cnt - r0), 32'd0);
      check("faults_wcnt", 32'(wr_cnt - w0), 32'd0);

      // Back-to-back with req_valid held high.
      issue(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 2, "b2b_ld", 1'b1);
      issue(1'b1, SZ_WORD, 1'b0, 32'h14, 32'h0000CAFE, 32'h0, 1'b0, 1'b0, 2, "b2b_st", 1'b1);
      issue(1'b0, SZ_HALF, 1'b0, 32'h14, 32'h0, 32'h0000CAFE, 1'b0, 1'b0, 2, "b2b_ldh", 1'b0);
      wait_drain("b2b");

      // Reset during the RD phase of a byte store.
      w0 = wr_cnt;
      req_write = 1'b1; req_size = SZ_BYTE; req_signed = 1'b0;
      req_addr = 32'h31; req_wdata = 32'h99; req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      check("mid_rd_active", 32'(mem_read), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_mem_read", 32'(mem_read), 32'd0);
      check("mid_mem_write", 32'(mem_write), 32'd0);
      check("mid_req_ready", 32'(req_ready), 32'd1);
      check("mid_resp_valid", 32'(resp_valid), 32'd0);
      check("mid_mem_addr", mem_addr, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("mid_mem_unchanged", mem[12], 32'h55667788);
      check("mid_wcnt", 32'(wr_cnt - w0), 32'd0);
      check("mid_ready_after", 32'(req_ready), 32'd1);

      check("rd_wr_exclusive", 32'(both_seen), 32'd0);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
